ula_arbiter: RTL

- Shares the single ULA between two requesters: port 0 (execute stage) and port 1 (branch/address unit).
- Uses round-robin arbitration, with one operation in flight at a time.
- Drives the ULA opcode and operands from registers and holds them stable for a programmable number of cycles.
- Captures the result and flags, then returns them to the requester that owns the operation through a valid/ready response.

---
 rtl/ula_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/ula_arbiter.sv
// Round-robin arbiter sharing one ULA between the execute stage (port 0)
// and the branch/address unit (port 1); one operation in flight at a time.
module ula_arbiter #(
  parameter int DATA_W  = 32,
  parameter int OP_W    = 5,
  parameter int ALU_LAT = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_opcode,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_opcode,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data,
  output logic [3:0]        rsp0_flags,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data,
  output logic [3:0]        rsp1_flags,
  output logic [OP_W-1:0]   alu_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  input  logic              alu_neg,
  input  logic              alu_carry,
  input  logic              alu_overflow,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_e;

  localparam logic [OP_W-1:0] OP_RST =
    {1'b1, {(OP_W-1){1'b0}}};
  localparam logic [3:0] LAT = 4'(ALU_LAT);

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [3:0]        flg_q, flg_d;

  logic gnt0, gnt1;

  // last_q doubles as the owner of the in-flight operation
  assign gnt0 = req0_valid & (~req1_valid | last_q);
  assign gnt1 = req1_valid & (~req0_valid | ~last_q);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      op_q    <= OP_RST;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    flg_d      = flg_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        req0_ready = gnt0;
        req1_ready = gnt1;
        if (gnt0 || gnt1) begin
          state_d = ISSUE;
          last_d  = gnt1;
          cnt_d   = LAT;
          op_d    = gnt1 ? req1_opcode : req0_opcode;
          a_d     = gnt1 ? req1_a : req0_a;
          b_d     = gnt1 ? req1_b : req0_b;
        end
      end
      ISSUE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          res_d   = alu_out;
          flg_d   = {alu_zero, alu_neg,
                     alu_carry, alu_overflow};
        end
      end
      RESP: begin
        if (last_q ? rsp1_ready : rsp0_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp0_valid = (state_q == RESP) & ~last_q;
  assign rsp1_valid = (state_q == RESP) & last_q;
  assign rsp0_data  = rsp0_valid ? res_q : '0;
  assign rsp1_data  = rsp1_valid ? res_q : '0;
  assign rsp0_flags = rsp0_valid ? flg_q : '0;
  assign rsp1_flags = rsp1_valid ? flg_q : '0;

  assign alu_opcode = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign busy       = (state_q != IDLE);

endmodule
